// File: rtl/alu_wb_if.sv
// ALU result bus from the execute stage into the writeback stage.
//   valid/ready : handshake (ready driven by the consumer)
//   y, z, cy    : ALU result and flags
//   rd, wr_en   : destination register and its write enable
//   flag_en     : result updates the Z/CY flags
interface alu_wb_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] y;
  logic              z;
  logic              cy;
  logic [REG_AW-1:0] rd;
  logic              wr_en;
  logic              flag_en;

  modport master (output valid, y, z, cy, rd, wr_en, flag_en, input ready);
  modport slave  (input valid, y, z, cy, rd, wr_en, flag_en, output ready);
endinterface

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: buffers ALU results in a 2-entry skid FIFO, retires them to the
// register-file write port, owns the speculative/committed Z/CY flags and supplies
// operand-forwarding data for the youngest buffered write.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   ex (slave)           ALU result bus; ex.ready is registered
//   flush                drop every buffered, unretired entry
//   wb_ready             register file accepts a write this cycle
//   rf_we/waddr/wdata    register-file write port (combinational from the head entry)
//   p_z, p_cy            speculative flags to the ALU (registered)
//   fwd_valid/rd/data    youngest buffered entry that writes a register
//
// Optional feature: define WB_PERF_CNT_EN to add retire_cnt/stall_cnt output counters.
module alu_wb_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_wb_if.slave           ex,
  input  logic              flush,
  input  logic              wb_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              p_z,
  output logic              p_cy,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`ifdef WB_PERF_CNT_EN
  ,
  output logic [15:0]       retire_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic              z;
    logic              cy;
    logic [REG_AW-1:0] rd;
    logic              wr_en;
    logic              flag_en;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t in_e;
  logic   ex_ready_q, ex_ready_d;
  logic   spec_z_q, spec_z_d, spec_cy_q, spec_cy_d;
  logic   com_z_q, com_z_d, com_cy_q, com_cy_d;
  logic   head_valid, accept, retire;

  always_comb begin
    in_e.y       = ex.y;
    in_e.z       = ex.z;
    in_e.cy      = ex.cy;
    in_e.rd      = ex.rd;
    in_e.wr_en   = ex.wr_en;
    in_e.flag_en = ex.flag_en;
  end

  assign head_valid = (state_q != StEmpty);
  assign accept     = ex.valid & ex_ready_q & ~flush;
  // A flush blocks the register write, so only a head without wr_en can retire in that cycle.
  assign retire     = head_valid & (~head_q.wr_en | (wb_ready & ~flush));

  assign rf_we    = head_valid & head_q.wr_en & ~flush;
  assign rf_waddr = head_q.rd;
  assign rf_wdata = head_q.y;
  assign ex.ready = ex_ready_q;
  assign p_z      = spec_z_q;
  assign p_cy     = spec_cy_q;

  // FIFO occupancy and storage next state.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            head_d  = in_e;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && retire) begin
            head_d = in_e;
          end else if (accept) begin
            tail_d  = in_e;
            state_d = StTwo;
          end else if (retire) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (retire) begin
            head_d  = tail_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    ex_ready_d = (state_d != StTwo);
  end

  // Flags: committed follow retirement; speculative follow acceptance, and on flush
  // fall back to the committed value including any head retiring this very cycle.
  always_comb begin
    com_z_d   = com_z_q;
    com_cy_d  = com_cy_q;
    spec_z_d  = spec_z_q;
    spec_cy_d = spec_cy_q;
    if (retire && head_q.flag_en) begin
      com_z_d  = head_q.z;
      com_cy_d = head_q.cy;
    end
    if (flush) begin
      spec_z_d  = com_z_d;
      spec_cy_d = com_cy_d;
    end else if (accept && ex.flag_en) begin
      spec_z_d  = ex.z;
      spec_cy_d = ex.cy;
    end
  end

  // Forward the youngest buffered entry that writes a register.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    if (state_q == StTwo && tail_q.wr_en) begin
      fwd_valid = 1'b1;
      fwd_rd    = tail_q.rd;
      fwd_data  = tail_q.y;
    end else if (head_valid && head_q.wr_en) begin
      fwd_valid = 1'b1;
      fwd_rd    = head_q.rd;
      fwd_data  = head_q.y;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      head_q     <= '0;
      tail_q     <= '0;
      ex_ready_q <= 1'b1;
      spec_z_q   <= 1'b0;
      spec_cy_q  <= 1'b0;
      com_z_q    <= 1'b0;
      com_cy_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      ex_ready_q <= ex_ready_d;
      spec_z_q   <= spec_z_d;
      spec_cy_q  <= spec_cy_d;
      com_z_q    <= com_z_d;
      com_cy_q   <= com_cy_d;
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [15:0] retire_cnt_q, retire_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (retire && !flush) begin
      retire_cnt_d = retire_cnt_q + 16'd1;
    end
    if (rf_we && !wb_ready) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule
